// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator execution engine.
// No logic; opcode 111 decodes as MUL when CALC_MUL_EN is defined, else MOV.
// Backpressure: not applicable (types only).
package calc_pkg;

  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
`ifdef CALC_MUL_EN
    OP_MUL = 3'b111
`else
    OP_MOV = 3'b111
`endif
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_MUL  = 3'd3,
    ST_WB   = 3'd4
  } state_t;

endpackage

// File: rtl/calc_regfile.sv
// NREGS x WIDTH register file: one write port, two captured operand reads, one combinational read.
// Latency: writes visible the cycle after the edge; operand capture registered on cap_en_i.
// Backpressure: none; an engine write and a load in the same cycle drop the load (ld_drop_o).
module calc_regfile
  import calc_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int NREGS = 8,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             eng_we_i,
  input  logic [RW-1:0]    eng_reg_i,
  input  logic [WIDTH-1:0] eng_data_i,
  input  logic             ld_en_i,
  input  logic [RW-1:0]    ld_reg_i,
  input  logic [WIDTH-1:0] ld_data_i,
  output logic             ld_drop_o,
  input  logic             cap_en_i,
  input  logic [RW-1:0]    ra_a_i,
  input  logic [RW-1:0]    ra_b_i,
  output logic [WIDTH-1:0] op_a_o,
  output logic [WIDTH-1:0] op_b_o,
  input  logic [RW-1:0]    rd_reg_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;

  // There is only one write port, so a load competing with write-back loses.
  assign ld_drop_o = ld_en_i & eng_we_i;

  // Single write port: engine write-back has priority over a direct load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (eng_we_i) begin
      regs_q[eng_reg_i] <= eng_data_i;
    end else if (ld_en_i) begin
      regs_q[ld_reg_i] <= ld_data_i;
    end
  end

  // Operand snapshot: later loads to these registers do not disturb the running command.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_a_q <= '0;
      op_b_q <= '0;
    end else if (cap_en_i) begin
      op_a_q <= regs_q[ra_a_i];
      op_b_q <= regs_q[ra_b_i];
    end
  end

  assign op_a_o    = op_a_q;
  assign op_b_o    = op_b_q;
  assign rd_data_o = regs_q[rd_reg_i];

endmodule

// File: rtl/calc_engine.sv
// Register-file ALU engine: one command at a time, IDLE->READ->EXEC->(MUL)->WB; MUL built under CALC_MUL_EN.
// Latency: result written back 3 edges after acceptance, 3+WIDTH for MUL.
// Backpressure: cmd_ready low from the cycle after acceptance through WB; loads dropped (wr_err) only in WB.
module calc_engine
  import calc_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int NREGS = 8,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic             hz100,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [RW-1:0]    cmd_src1,
  input  logic [RW-1:0]    cmd_src2,
  input  logic [RW-1:0]    cmd_dst,
  input  logic             wr_en,
  input  logic [RW-1:0]    wr_reg,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_err,
  input  logic [RW-1:0]    rd_reg,
  output logic [WIDTH-1:0] rd_data,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);

  state_t           state_q, state_d;
  op_t              op_q;
  logic [RW-1:0]    src1_q, src2_q, dst_q;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] alu_res, alu_res_q;
  logic             alu_ovf, alu_ovf_q;
  logic [WIDTH-1:0] wb_data;
  logic             wb_ovf;
  logic [WIDTH-1:0] res_data_q;
  logic             res_ovf_q, res_valid_q, wr_err_q;
  logic             ld_drop;
  logic             accept;
  logic             in_wb;
  logic [SW-1:0]    amt;
  logic [3*WIDTH-1:0] shl_wide;

  assign accept = cmd_valid & cmd_ready;
  assign in_wb  = (state_q == ST_WB);

  calc_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
    .clk_i      (hz100),
    .rst_i      (reset),
    .eng_we_i   (in_wb),
    .eng_reg_i  (dst_q),
    .eng_data_i (wb_data),
    .ld_en_i    (wr_en),
    .ld_reg_i   (wr_reg),
    .ld_data_i  (wr_data),
    .ld_drop_o  (ld_drop),
    .cap_en_i   (state_q == ST_READ),
    .ra_a_i     (src1_q),
    .ra_b_i     (src2_q),
    .op_a_o     (op_a),
    .op_b_o     (op_b),
    .rd_reg_i   (rd_reg),
    .rd_data_o  (rd_data)
  );

`ifdef CALC_MUL_EN
  localparam int CW = (SW < 1) ? 1 : SW;

  logic [2*WIDTH-1:0] acc_q, mcand_q, prod;
  logic [WIDTH-1:0]   mplier_q, mag_a, mag_b, mul_res;
  logic [CW-1:0]      mul_cnt_q;
  logic               neg_q, mul_ovf;

  // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
  assign mag_a = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
  assign mag_b = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;

  // Shift-add multiplier over magnitudes, one multiplier bit per cycle.
  always_ff @(posedge hz100) begin
    if (reset) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      mul_cnt_q <= '0;
    end else if (state_q == ST_EXEC) begin
      acc_q     <= '0;
      mcand_q   <= {{WIDTH{1'b0}}, mag_a};
      mplier_q  <= mag_b;
      neg_q     <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
      mul_cnt_q <= '0;
    end else if (state_q == ST_MUL) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q   <= mcand_q << 1;
      mplier_q  <= mplier_q >> 1;
      mul_cnt_q <= mul_cnt_q + CW'(1);
    end
  end

  // Sign applied once at the end; overflow when the signed product does not fit WIDTH bits.
  assign prod    = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign mul_res = prod[WIDTH-1:0];
  assign mul_ovf = (prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod[WIDTH-1]}});
`endif

  // Command fields are sampled only at acceptance.
  always_ff @(posedge hz100) begin
    if (reset) begin
      op_q   <= OP_ADD;
      src1_q <= '0;
      src2_q <= '0;
      dst_q  <= '0;
    end else if (accept) begin
      op_q   <= op_t'(cmd_op);
      src1_q <= cmd_src1;
      src2_q <= cmd_src2;
      dst_q  <= cmd_dst;
    end
  end

  // FSM state register.
  always_ff @(posedge hz100) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state and ready.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = ST_READ;
      end
      ST_READ: state_d = ST_EXEC;
`ifdef CALC_MUL_EN
      ST_EXEC: state_d = (op_q == OP_MUL) ? ST_MUL : ST_WB;
      ST_MUL:  if (mul_cnt_q == CW'(WIDTH-1)) state_d = ST_WB;
`else
      ST_EXEC: state_d = ST_WB;
      ST_MUL:  state_d = ST_IDLE;
`endif
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign amt = op_b[SW-1:0];

  // Single-cycle ALU on the captured operands.
  always_comb begin
    alu_res  = '0;
    alu_ovf  = 1'b0;
    // Triple width holds every bit shifted out for any amount below 2*WIDTH.
    shl_wide = {{(2*WIDTH){op_a[WIDTH-1]}}, op_a} << amt;
    case (op_q)
      OP_ADD: begin
        alu_res = op_a + op_b;
        alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = op_a - op_b;
        alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_SHL: begin
        alu_res = shl_wide[WIDTH-1:0];
        alu_ovf = (shl_wide[3*WIDTH-1:WIDTH-1] != {(2*WIDTH+1){op_a[WIDTH-1]}});
      end
      OP_SHR: alu_res = $signed(op_a) >>> amt;
`ifdef CALC_MUL_EN
      OP_MUL: alu_res = '0;
`else
      OP_MOV: alu_res = op_a;
`endif
      default: alu_res = '0;
    endcase
  end

  // EXEC stores the ALU outcome for write-back.
  always_ff @(posedge hz100) begin
    if (reset) begin
      alu_res_q <= '0;
      alu_ovf_q <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      alu_res_q <= alu_res;
      alu_ovf_q <= alu_ovf;
    end
  end

  // Write-back source: multiplier output for MUL, stored ALU result otherwise.
  always_comb begin
    wb_data = alu_res_q;
    wb_ovf  = alu_ovf_q;
`ifdef CALC_MUL_EN
    if (op_q == OP_MUL) begin
      wb_data = mul_res;
      wb_ovf  = mul_ovf;
    end
`endif
  end

  // Result/status registers: pulses follow the WB edge, data held until the next write-back.
  always_ff @(posedge hz100) begin
    if (reset) begin
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      res_valid_q <= in_wb;
      wr_err_q    <= ld_drop;
      if (in_wb) begin
        res_data_q <= wb_data;
        res_ovf_q  <= wb_ovf;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ovf   = res_ovf_q;
  assign wr_err    = wr_err_q;
  assign busy      = ~cmd_ready;

endmodule

// File: tb/tb_calc_engine.sv
// Bench for calc_engine: transaction-level reference model plus directed literal cases and random traffic.
// Checks every cycle at the falling edge; inputs change 1 time unit after the rising edge.
// Optional MUL behaviour follows CALC_MUL_EN, same as the design.
module tb_calc_engine;

  localparam int W  = 9;
  localparam int N  = 8;
  localparam int RW = 3;
  localparam int SW = 4;
`ifdef CALC_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic          hz100 = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd_op = '0;
  logic [RW-1:0] cmd_src1 = '0, cmd_src2 = '0, cmd_dst = '0;
  logic          wr_en = 1'b0;
  logic [RW-1:0] wr_reg = '0;
  logic [W-1:0]  wr_data = '0;
  logic [RW-1:0] rd_reg = '0;
  logic          cmd_ready, wr_err, res_valid, res_ovf, busy;
  logic [W-1:0]  rd_data, res_data;

  calc_engine #(.WIDTH(W), .NREGS(N)) dut (
    .hz100(hz100), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .wr_err(wr_err),
    .rd_reg(rd_reg), .rd_data(rd_data),
    .res_valid(res_valid), .res_data(res_data), .res_ovf(res_ovf), .busy(busy)
  );

  always #5 hz100 = ~hz100;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference arithmetic on signed integers: {ovf, result}.
  function automatic logic [W:0] ref_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, full, lo, hi;
    int amt;
    logic [63:0] bits;
    bit rng;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    amt = int'(b) % (1 << SW);
    lo  = -(longint'(1) << (W-1));
    hi  = (longint'(1) << (W-1)) - 1;
    rng = 1'b0;
    full = 0;
    case (op)
      0: begin full = sa + sb; rng = 1'b1; end
      1: begin full = sa - sb; rng = 1'b1; end
      2: full = longint'(a & b);
      3: full = longint'(a | b);
      4: full = longint'(a ^ b);
      5: begin full = sa * (longint'(1) << amt); rng = 1'b1; end
      6: full = sa >>> amt;
      default: begin
        if (MUL_ON) begin full = sa * sb; rng = 1'b1; end
        else full = sa;
      end
    endcase
    bits = full;
    return {rng && (full < lo || full > hi), bits[W-1:0]};
  endfunction

  // Transaction model: one outstanding command, ages counted in clock edges since acceptance.
  logic [W-1:0] m_regs [N];
  bit           m_act = 1'b0, m_wb;
  int           m_age, m_lat, m_op, m_s1, m_s2, m_d;
  logic [W-1:0] m_a, m_b, e_res = '0;
  logic [W:0]   m_r;
  bit           e_ovf = 1'b0, e_rv = 1'b0, e_err = 1'b0;

  always @(posedge hz100) begin
    if (reset) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_act = 1'b0; e_res = '0; e_ovf = 1'b0; e_rv = 1'b0; e_err = 1'b0;
    end else begin
      m_wb = 1'b0; e_rv = 1'b0; e_err = 1'b0;
      if (m_act) begin
        m_age++;
        if (m_age == 1) begin
          m_a = m_regs[m_s1];
          m_b = m_regs[m_s2];
        end
        if (m_age == m_lat) begin
          m_r = ref_op(m_op, m_a, m_b);
          m_regs[m_d] = m_r[W-1:0];
          e_res = m_r[W-1:0];
          e_ovf = m_r[W];
          e_rv  = 1'b1;
          m_act = 1'b0;
          m_wb  = 1'b1;
        end
      end else if (cmd_valid) begin
        m_act = 1'b1; m_age = 0;
        m_op = int'(cmd_op); m_s1 = int'(cmd_src1); m_s2 = int'(cmd_src2); m_d = int'(cmd_dst);
        m_lat = (MUL_ON && m_op == 7) ? 3 + W : 3;
      end
      if (wr_en) begin
        if (m_wb) e_err = 1'b1;
        else m_regs[wr_reg] = wr_data;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge hz100) begin
    if (checking) begin
      chk("cmd_ready", cmd_ready, !m_act);
      chk("busy", busy, m_act);
      chk("res_valid", res_valid, e_rv);
      chk("wr_err", wr_err, e_err);
      chk("res_data", res_data, e_res);
      chk("res_ovf", res_ovf, e_ovf);
      chk("rd_data", rd_data, m_regs[rd_reg]);
    end
  end

  task automatic tick();
    @(posedge hz100);
    #1;
  endtask

  task automatic load(input int r, input logic [W-1:0] v);
    wr_en = 1'b1; wr_reg = RW'(r); wr_data = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100 && !cmd_ready; i++) tick();
    if (!cmd_ready) chk("ready_timeout", cmd_ready, 1);
  endtask

  task automatic set_cmd(input int op, input int s1, input int s2, input int d);
    cmd_op = 3'(op); cmd_src1 = RW'(s1); cmd_src2 = RW'(s2); cmd_dst = RW'(d);
  endtask

  task automatic issue(input int op, input int s1, input int s2, input int d);
    wait_ready();
    set_cmd(op, s1, s2, d);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!res_valid && lat < 100);
    if (!res_valid) chk("res_timeout", res_valid, 1);
  endtask

  task automatic run(input string nm, input int op, input int s1, input int s2, input int d,
                     input int elat, input logic [W-1:0] edat, input logic eovf);
    int lat;
    issue(op, s1, s2, d);
    wait_res(lat);
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_data"}, res_data, edat);
    chk({nm, "_ovf"}, res_ovf, eovf);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    checking = 1'b1;

    // Reset state.
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_ovf", res_ovf, 0);
    chk("rst_wr_err", wr_err, 0);
    for (int i = 0; i < N; i++) begin
      rd_reg = RW'(i); #1;
      chk("rst_reg", rd_data, 0);
    end

    // ADD with signed overflow: 100 + 200 wraps to -212.
    load(1, 9'd100); load(2, 9'd200);
    run("add", 0, 1, 2, 3, 3, 9'h12C, 1'b1);
    rd_reg = 3; #1;
    chk("add_rd", rd_data, 9'h12C);

    load(1, 9'd5); load(2, 9'd7);
    run("sub", 1, 1, 2, 4, 3, 9'h1FE, 1'b0);
    load(1, 9'h1F8); load(2, 9'd2);
    run("shr", 6, 1, 2, 5, 3, 9'h1FE, 1'b0);
    load(1, 9'd64); load(2, 9'd2);
    run("shl", 5, 1, 2, 6, 3, 9'h100, 1'b1);
    load(2, 9'd12);
    run("shl_big", 5, 1, 2, 6, 3, 9'h000, 1'b1);

`ifdef CALC_MUL_EN
    load(1, 9'd12); load(2, 9'h1F6);
    run("mul", 7, 1, 2, 7, 12, 9'h188, 1'b0);
    load(1, 9'd20); load(2, 9'd20);
    run("mul_ovf", 7, 1, 2, 7, 12, 9'h190, 1'b1);
`else
    load(1, 9'd77); load(2, 9'd3);
    run("mov", 7, 1, 2, 7, 3, 9'd77, 1'b0);
`endif

    // Load colliding with write-back is dropped.
    load(1, 9'd1); load(2, 9'd2);
    rd_reg = 3;
    issue(0, 1, 2, 3);
    tick(); tick();
    wr_en = 1'b1; wr_reg = 3; wr_data = 9'h055;
    tick();
    wr_en = 1'b0;
    chk("wb_drop_rv", res_valid, 1);
    chk("wb_drop_err", wr_err, 1);
    chk("wb_drop_reg", rd_data, 9'd3);
    tick();
    chk("wb_drop_err_clr", wr_err, 0);

    // Load during EXEC is stored, then overwritten by write-back.
    issue(0, 1, 2, 3);
    tick();
    wr_en = 1'b1; wr_reg = 3; wr_data = 9'h077;
    tick();
    wr_en = 1'b0;
    chk("exec_ld_reg", rd_data, 9'h077);
    chk("exec_ld_err", wr_err, 0);
    tick();
    chk("exec_ld_rv", res_valid, 1);
    chk("exec_ld_wb", rd_data, 9'd3);

    // Load in the acceptance cycle is seen by the command.
    load(2, 9'd3);
    wait_ready();
    set_cmd(0, 1, 2, 4);
    cmd_valid = 1'b1; wr_en = 1'b1; wr_reg = 1; wr_data = 9'd10;
    tick();
    cmd_valid = 1'b0; wr_en = 1'b0;
    wait_res(lat);
    chk("same_cyc_data", res_data, 9'd13);

    // Load in READ does not affect the captured operand.
    issue(0, 1, 2, 4);
    wr_en = 1'b1; wr_reg = 1; wr_data = 9'd50;
    tick();
    wr_en = 1'b0;
    wait_res(lat);
    chk("read_ld_lat", lat, 2);
    chk("read_ld_data", res_data, 9'd13);
    rd_reg = 1; #1;
    chk("read_ld_reg", rd_data, 9'd50);

    // Reset mid-command aborts it.
    load(1, 9'd12); load(2, 9'd3);
    issue(7, 1, 2, 5);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_ready", cmd_ready, 1);
    for (int i = 0; i < 15; i++) begin
      chk("abort_no_rv", res_valid, 0);
      tick();
    end
    for (int i = 0; i < N; i++) begin
      rd_reg = RW'(i); #1;
      chk("abort_reg", rd_data, 0);
    end

    // Random traffic; second half holds cmd_valid high continuously.
    for (int i = 0; i < 1200; i++) begin
      cmd_valid = (i >= 600) ? 1'b1 : ($urandom_range(0, 2) == 0);
      set_cmd($urandom_range(0, 7), $urandom_range(0, N-1), $urandom_range(0, N-1), $urandom_range(0, N-1));
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_reg  = RW'($urandom_range(0, N-1));
      wr_data = W'($urandom);
      rd_reg  = RW'($urandom_range(0, N-1));
      tick();
    end
    cmd_valid = 1'b0;
    wr_en = 1'b0;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_engine.md
# calc_engine

Parametrised register-file/ALU execution engine for the calculator datapath. It accepts a three-operand command (src1, src2, dst, opcode) over a valid/ready handshake, reads both operands from an internal register file, executes in a sequenced FSM, and writes the result back to the register file. It also reports the result and an overflow flag to the display/status logic. It generalises the fixed 9-bit, 8-register, single-operand-stream datapath to arbitrary width and depth, with multi-cycle multiply and direct register loads from the keypad path.

## Interface
- WIDTH, 9: data width, two's complement, ≥4
- NREGS, 8: register count, power of two, ≥2; RW = $clog2(NREGS)
- hz100  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine idle, can accept a command
- cmd_op  in  3  opcode
- cmd_src1, cmd_src2, cmd_dst  in  RW each  register indices
- wr_en  in  1  direct register load, e.g. a keypad operand
- wr_reg  in  RW  load target
- wr_data  in  WIDTH  load value
- wr_err  out  1  one-cycle pulse when a load is dropped
- rd_reg  in  RW  debug/display read index
- rd_data  out  WIDTH  combinational contents of rd_reg
- res_valid  out  1  one-cycle pulse when the result is written back
- res_data  out  WIDTH  last result, held until the next write-back
- res_ovf  out  1  overflow flag of the last result, held
- busy  out  1  equals ~cmd_ready

## Operation
- Opcodes:
  - 000 ADD
  - 001 SUB (src1−src2)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL
  - 110 SHR (arithmetic)
  - 111 MUL
- Shift amount is the unsigned value of src2[$clog2(WIDTH)-1:0]. An amount ≥WIDTH yields 0 for SHL, and sign fill for SHR.
- Overflow rules:
  - ADD/SUB: signed overflow.
  - SHL: set if any bit shifted out, or the result sign, differs from the original sign.
  - AND/OR/XOR/SHR: ovf = 0.
  - MUL: low WIDTH bits of the signed product; ovf set if the full product is not representable in WIDTH bits.
- MUL algorithm: iterative shift-add over operand magnitudes, one bit per cycle, sign applied at the end.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, latch op/src/dst and go to READ.
  - READ: latch both operands. Go to EXEC.
  - EXEC: non-MUL ops compute into the result register, then go to WB. MUL initialises the accumulator, then goes to MUL.
  - MUL: runs WIDTH cycles, then goes to WB.
  - WB: write the result to dst, update res_data/res_ovf, pulse res_valid, go to IDLE.
- src1==src2==dst is legal. Operands are captured in READ, before WB.
- Direct loads:
  - wr_en is honoured in any state except WB.
  - In WB, the engine write wins, the load is dropped, and wr_err pulses.
  - A load in the same cycle as command acceptance lands before READ, so the command sees the new value.
  - A load to a register already read in READ does not affect the running command.
- Reset values:
  - All registers 0; res_data 0; res_ovf 0.
  - res_valid 0; wr_err 0; state IDLE; cmd_ready 1.
- Reset mid-operation aborts the command: no write-back, no res_valid.

## Timing
- Command accepted at edge N (cmd_valid & cmd_ready).
- Non-MUL: WB occupies cycle N+3. The register file, res_data and res_valid are visible after edge N+3.
- MUL: latency N+3+WIDTH (N+12 at WIDTH=9).
- cmd_ready is low from the cycle after acceptance through WB. The next command can be accepted in the cycle after WB.
- rd_data reflects a write in the cycle after that write's edge.
- cmd_* are sampled only at acceptance and may change afterwards.

## Configuration
- CALC_MUL_EN defined: opcode 111 is MUL, as above, and the MUL state and accumulator are built.
- CALC_MUL_EN undefined: opcode 111 is MOV (result = src1, ovf 0, non-MUL latency), and no multiplier logic is synthesised.

## Structure
- calc_pkg holds:
  - op_t enum (ADD..MUL/MOV encodings)
  - state_t enum (IDLE, READ, EXEC, MUL, WB)
  - opcode width constant
- One sub-module, calc_regfile: NREGS×WIDTH registers, one write port (engine write priority over load, drop flag), two registered-capture read ports and one combinational read port.
- The FSM and ALU stay in calc_engine.

## Test plan
- Load R1=100, R2=200; ADD dst R3 -> res_valid exactly 3 cycles after acceptance; res_data=9'h12C (−212); res_ovf=1; rd_reg=3 reads 9'h12C.
- Load R1=5, R2=7; SUB -> 9'h1FE (−2), ovf=0. Load R1=−8, R2=2; SHR -> 9'h1FE. SHL of 64 by 2 -> 9'h100, ovf=1.
- With CALC_MUL_EN: R1=12, R2=−10; MUL -> res_valid at acceptance+12; 9'h188 (−120), ovf=0. Then 20×20 -> ovf=1. Without the macro: 111 returns R1 after 3 cycles.
- wr_en to the dst register during the WB cycle -> engine value stored, wr_err pulses for one cycle. The same load during EXEC -> stored, no wr_err.
- Assert reset during the MUL state -> next cycle cmd_ready=1, res_valid never pulses, all registers read 0.
- Hold cmd_valid high continuously -> commands are accepted only when cmd_ready=1, with no lost or duplicated commands. Command-then-load-same-cycle ordering is checked.
